arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, job queue entries (power of two, >=2).
REQ-002 Parameter DATA_W, default 8, job/bus data width.
REQ-003 Parameter TIMEOUT, default 15, REQ-state wait cycles without grant before starve asserts.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 job_valid  input  1  a job is offered this cycle.
REQ-007 job_ready  output  1  the queue can accept a job this cycle.
REQ-008 job_len  input  4  burst length in beats; 0 is treated as 1.
REQ-009 job_data  input  DATA_W  base data value of the job.
REQ-010 req_out  output  1  request line to the arbiter's req_in bit.
REQ-011 grant_in  input  1  grant line from the arbiter's grant_out bit.
REQ-012 bus_valid  output  1  a beat is driven on the shared bus this cycle.
REQ-013 bus_data  output  DATA_W  beat payload.
REQ-014 bus_last  output  1  the current beat is the final beat of the job.
REQ-015 starve  output  1  grant has not arrived within TIMEOUT cycles.
REQ-016 busy  output  1  the FSM is not IDLE or the queue is non-empty.

Function
REQ-017 The block SHALL accept a job on any rising edge where job_valid=1 and job_ready=1; job_ready=1 iff the queue count < FIFO_DEPTH, based on the pre-edge count.
REQ-018 A push offered while full SHALL be dropped, even when a pop occurs on the same edge; a push and a pop on the same edge with count < FIFO_DEPTH SHALL leave count unchanged.
REQ-019 FSM states: IDLE, REQ, XFER, REL; state register updates on the clock edge.
REQ-020 IDLE -> REQ when the queue is non-empty; otherwise IDLE holds.
REQ-021 A job accepted at edge t into an empty idle block SHALL drive req_out=1 from edge t+1.
REQ-022 req_out SHALL be 1 in REQ and XFER and 0 in IDLE and REL.
REQ-023 REQ -> XFER on an edge where grant_in=1; beat index is preserved (0 for a new job).
REQ-024 In XFER, bus_valid SHALL equal grant_in combinationally; bus_data = head.job_data + beat index, modulo 2^DATA_W; bus_last=1 when beat index = effective length-1 and bus_valid=1.
REQ-025 In XFER, each edge with grant_in=1 SHALL increment the beat index; on the last beat the head job SHALL be popped, the beat index cleared, and the FSM SHALL go to REL.
REQ-026 If grant_in=0 on an XFER edge (preemption), the FSM SHALL go to REQ, keep the beat index, and resume at that beat when the grant returns.
REQ-027 REL SHALL last exactly one cycle with req_out=0, then go to IDLE, so the round-robin arbiter can rotate.
REQ-028 grant_in SHALL be ignored in IDLE and REL: bus_valid=0 and no state change results.
REQ-029 The wait counter SHALL increment on each REQ edge with grant_in=0, saturating at TIMEOUT.
REQ-030 starve SHALL equal (wait counter == TIMEOUT); the counter SHALL clear on entry to XFER.
REQ-031 bus_data and bus_last SHALL be 0 whenever bus_valid=0.
REQ-032 busy SHALL be (state != IDLE) or (count != 0).

Reset
REQ-033 While rst=1, asynchronously: FSM=IDLE, queue empty, beat index=0, wait counter=0.
REQ-034 While rst=1, outputs SHALL be: req_out=0, bus_valid=0, bus_data=0, bus_last=0, starve=0, busy=0, job_ready=1.
REQ-035 Reset asserted mid-XFER SHALL discard all queued and partially sent jobs; no beat is driven after deassertion until a new job is accepted.

Verification
REQ-036 One job (len=3, data=0x10), grant_in tied high: req_out rises 1 edge after accept; beats 0x10, 0x11, 0x12 are driven with bus_last on 0x12; then one REL cycle with req_out=0; then idle with busy=0.
REQ-037 Five back-to-back job offers with no grant: the first 4 are accepted, and job_ready=0 during the 5th offer; starve=1 after 15 REQ cycles; on grant, starve clears and 4 bursts drain in order, each separated by a REL cycle.
REQ-038 A len=4 job with grant dropped after beat 1 for 3 cycles: bus_valid=0 during the gap, req_out stays 1, and the burst resumes at beat 2 (data+2).
REQ-039 A job with len=0 and data=0xFF: exactly one beat, 0xFF, with bus_last=1; a job with len=2 and data=0xFF produces beats 0xFF, then 0x00 (wrap).
REQ-040 rst pulsed during beat 1 of a 3-beat job with 2 jobs queued: all outputs go to their reset values immediately; after release, no req_out appears until a new job is accepted.

Source files
------------

// File: rtl/arb_requester.sv
// arb_requester: queues burst jobs and presents them to one port of a shared
// round-robin arbiter. Each job becomes a burst of beats on the bus. The data
// for beat i is the job's base data plus i. The burst can be preempted, and it
// resumes at the interrupted beat.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   job_valid/job_ready job offer handshake (job_len, job_data payload)
//   job_len             burst length in beats, 0 treated as 1
//   req_out, grant_in   arbiter request / grant
//   bus_valid/data/last beat presented on the shared bus
//   starve              grant not seen within TIMEOUT request cycles
//   busy                FSM active or queue non-empty
module arb_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [3:0]        job_len,
  input  logic [DATA_W-1:0] job_data,
  output logic              req_out,
  input  logic              grant_in,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              starve,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t            state, state_nxt;
  logic [3:0]        len_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [3:0]        beat;
  logic [WW-1:0]     wait_cnt;
  logic              push, pop;
  logic [3:0]        head_len, last_idx;
  logic [DATA_W-1:0] head_data;
  logic              is_last;

  // The full check uses the pre-edge count, so a push offered while the queue
  // is full is dropped even if a pop happens on the same edge.
  assign job_ready = (count < DEPTH_C);
  assign push      = job_valid & job_ready;
  assign head_len  = len_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign last_idx  = (head_len == 4'd0) ? 4'd0 : head_len - 4'd1;
  assign is_last   = (beat == last_idx);
  assign starve    = (wait_cnt == TIMEOUT_C);
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      len_mem[wr_ptr]  <= job_len;
      data_mem[wr_ptr] <= job_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // The beat index survives preemption; it is cleared only when a job completes.
      if (pop)
        beat <= '0;
      else if (state == XFER && grant_in)
        beat <= beat + 4'd1;
      if (state == REQ) begin
        if (grant_in)
          wait_cnt <= '0;
        else if (wait_cnt != TIMEOUT_C)
          wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    req_out   = 1'b0;
    bus_valid = 1'b0;
    case (state)
      IDLE: if (count != '0) state_nxt = REQ;
      REQ: begin
        req_out = 1'b1;
        if (grant_in) state_nxt = XFER;
      end
      XFER: begin
        req_out   = 1'b1;
        bus_valid = grant_in;
        if (!grant_in)
          state_nxt = REQ;
        else if (is_last) begin
          pop       = 1'b1;
          state_nxt = REL;
        end
      end
      REL: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus_data = bus_valid ? (head_data + DATA_W'(beat)) : '0;
  assign bus_last = bus_valid & is_last;

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
  localparam int D = 4;
  localparam int W = 8;
  localparam int T = 15;

  logic         clk = 1'b0;
  logic         rst, job_valid, job_ready, req_out, grant_in;
  logic         bus_valid, bus_last, starve, busy;
  logic [3:0]   job_len;
  logic [W-1:0] job_data, bus_data;

  always #5 clk = ~clk;

  arb_requester #(.FIFO_DEPTH(D), .DATA_W(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_len(job_len), .job_data(job_data), .req_out(req_out),
    .grant_in(grant_in), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_last(bus_last), .starve(starve), .busy(busy));

  // Reference model: a job list plus the protocol phase
  // (0 idle, 1 requesting, 2 transferring, 3 releasing).
  typedef struct { int len; int data; } job_t;
  job_t q[$];
  int   ph, beat, wt;
  int   cap[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic int eff(int l);
    return (l == 0) ? 1 : l;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ph = 0; beat = 0; wt = 0;
  endtask

  task automatic check_outputs();
    logic mv, ml;
    int   md;
    mv = (ph == 2) && grant_in;
    md = mv ? ((q[0].data + beat) % (1 << W)) : 0;
    ml = mv && (beat == eff(q[0].len) - 1);
    chk("job_ready", 32'(job_ready), 32'(q.size() < D));
    chk("req_out",   32'(req_out),   32'(ph == 1 || ph == 2));
    chk("bus_valid", 32'(bus_valid), 32'(mv));
    chk("bus_data",  32'(bus_data),  32'(md));
    chk("bus_last",  32'(bus_last),  32'(ml));
    chk("starve",    32'(starve),    32'(wt == T));
    chk("busy",      32'(busy),      32'(ph != 0 || q.size() != 0));
  endtask

  // Check at the falling edge, advance the model across the rising edge.
  task automatic cycle();
    int   nph, nbeat, nwt;
    bit   do_pop, do_push;
    job_t j;
    @(negedge clk);
    check_outputs();
    if (bus_valid) cap.push_back(int'(bus_data));
    nph = ph; nbeat = beat; nwt = wt; do_pop = 0;
    do_push = job_valid && (q.size() < D);
    j.len = int'(job_len); j.data = int'(job_data);
    case (ph)
      0: if (q.size() != 0) nph = 1;
      1: if (grant_in) begin nph = 2; nwt = 0; end
         else if (wt < T) nwt = wt + 1;
      2: if (!grant_in) nph = 1;
         else if (beat == eff(q[0].len) - 1) begin do_pop = 1; nbeat = 0; nph = 3; end
         else nbeat = beat + 1;
      default: nph = 0;
    endcase
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(j);
    ph = nph; beat = nbeat; wt = nwt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    job_valid = 1'b0;
    #1;
    chk("rst_req_out",   32'(req_out),   32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_data",  32'(bus_data),  32'd0);
    chk("rst_bus_last",  32'(bus_last),  32'd0);
    chk("rst_starve",    32'(starve),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic offer(input int len, input int data);
    job_valid = 1'b1;
    job_len   = 4'(len);
    job_data  = W'(data);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_len = '0; job_data = '0; grant_in = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Single 3-beat job with the grant tied high.
    grant_in = 1'b1;
    offer(3, 'h10);
    cycle();
    job_valid = 1'b0;
    cap.delete();
    repeat (8) cycle();
    chk("s1_nbeats", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      chk("s1_beat0", 32'(cap[0]), 32'h10);
      chk("s1_beat1", 32'(cap[1]), 32'h11);
      chk("s1_beat2", 32'(cap[2]), 32'h12);
    end
    chk("s1_busy_end", 32'(busy), 32'd0);

    // Five offers without a grant: the fifth sees a full queue; then starve.
    grant_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(2, 16 * (i + 1));
      if (i == 4) chk("s2_ready_5th", 32'(job_ready), 32'd0);
      cycle();
    end
    job_valid = 1'b0;
    repeat (20) cycle();
    chk("s2_starve", 32'(starve), 32'd1);
    grant_in = 1'b1;
    cap.delete();
    repeat (30) cycle();
    chk("s2_nbeats", 32'(cap.size()), 32'd8);
    if (cap.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("s2_beat", 32'(cap[i]), 32'(16 * (i / 2 + 1) + i % 2));

    // Preemption after beat 1 of a 4-beat job.
    offer(4, 'h40);
    cycle();
    job_valid = 1'b0;
    repeat (4) cycle();
    grant_in = 1'b0;
    repeat (3) begin
      cycle();
      chk("s3_gap_req", 32'(req_out), 32'd1);
    end
    grant_in = 1'b1;
    cap.delete();
    repeat (8) cycle();
    chk("s3_nbeats", 32'(cap.size()), 32'd2);
    if (cap.size() == 2) begin
      chk("s3_resume", 32'(cap[0]), 32'h42);
      chk("s3_final",  32'(cap[1]), 32'h43);
    end

    // Zero length and data wrap.
    cap.delete();
    offer(0, 'hFF);
    cycle();
    offer(2, 'hFF);
    cycle();
    job_valid = 1'b0;
    repeat (15) cycle();
    chk("s4_nbeats", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      chk("s4_len0", 32'(cap[0]), 32'hFF);
      chk("s4_b0",   32'(cap[1]), 32'hFF);
      chk("s4_wrap", 32'(cap[2]), 32'h00);
    end

    // Reset during beat 1 of a 3-beat job with more jobs queued.
    offer(3, 'h20); cycle();
    offer(3, 'h30); cycle();
    offer(3, 'h50); cycle();
    job_valid = 1'b0;
    cycle();
    do_reset();
    repeat (6) begin
      cycle();
      chk("s5_no_req", 32'(req_out), 32'd0);
    end

    // Random traffic, mostly granted.
    repeat (400) begin
      job_valid = ($urandom_range(0, 2) == 0);
      job_len   = 4'($urandom_range(0, 15));
      job_data  = W'($urandom);
      grant_in  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    // Random traffic with a scarce grant, to reach saturation of the wait counter.
    repeat (300) begin
      job_valid = ($urandom_range(0, 3) == 0);
      job_len   = 4'($urandom_range(0, 15));
      job_data  = W'($urandom);
      grant_in  = ($urandom_range(0, 24) == 0);
      cycle();
    end
    do_reset();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
